// File: rtl/write_buffer_if.sv
// Bus bundle between the cache, the write buffer and main memory.
// Writer-side modport is master; the write buffer uses slave.
interface write_buffer_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 128
) ();
  logic                  write_buffer_en;
  logic [ADDR_WIDTH-1:0] addr_to_write_buffer;
  logic [LINE_WIDTH-1:0] data_to_write_buffer;
  logic                  wb_full;
  logic                  wb_empty;
  logic                  wb_overflow;
  logic                  mem_wr_req;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [LINE_WIDTH-1:0] mem_wr_data;
  logic                  mem_wr_ack;
  logic                  lookup_en;
  logic [ADDR_WIDTH-1:0] lookup_addr;
  logic                  fwd_hit;
  logic [LINE_WIDTH-1:0] fwd_data;

  modport slave (
    input  write_buffer_en, addr_to_write_buffer, data_to_write_buffer,
    input  mem_wr_ack, lookup_en, lookup_addr,
    output wb_full, wb_empty, wb_overflow,
    output mem_wr_req, mem_wr_addr, mem_wr_data,
    output fwd_hit, fwd_data
  );

  modport master (
    output write_buffer_en, addr_to_write_buffer, data_to_write_buffer,
    output mem_wr_ack, lookup_en, lookup_addr,
    input  wb_full, wb_empty, wb_overflow,
    input  mem_wr_req, mem_wr_addr, mem_wr_data,
    input  fwd_hit, fwd_data
  );
endinterface

// File: rtl/write_buffer.sv
// Evicted-cacheline FIFO draining to main memory over req/ack.
// Define WRITE_BUFFER_FORWARD_EN to build the line-address forwarding comparators.
module write_buffer #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 128
) (
  input logic          clk,
  input logic          rst_n,
  write_buffer_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned OffW = $clog2(LINE_WIDTH / 8);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [LINE_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;
  logic                  overflow_q;
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                  full, empty, push, pop;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  // A push while full is dropped even if the head pops this same cycle.
  assign push  = bus.write_buffer_en && !full;
  assign pop   = (state_q == StReq) && bus.mem_wr_ack;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= bus.addr_to_write_buffer;
      data_q[wr_ptr_q] <= bus.data_to_write_buffer;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= StIdle;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + 1'b1;
      end
      if (push) begin
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
      if (bus.write_buffer_en && full) begin
        overflow_q <= 1'b1;
      end
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          state_d    = StReq;
          mem_addr_d = addr_q[rd_ptr_q];
          mem_data_d = data_q[rd_ptr_q];
        end
      end
      StReq: begin
        if (bus.mem_wr_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.wb_full     = full;
  assign bus.wb_empty    = empty;
  assign bus.wb_overflow = overflow_q;
  assign bus.mem_wr_req  = (state_q == StReq);
  assign bus.mem_wr_addr = mem_addr_q;
  assign bus.mem_wr_data = mem_data_q;

`ifdef WRITE_BUFFER_FORWARD_EN
  logic                  hit;
  logic [LINE_WIDTH-1:0] fdata;
  logic [PtrW-1:0]       idx;
  logic                  unused_lookup_lo;

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    hit   = 1'b0;
    fdata = '0;
    idx   = '0;
    if (bus.lookup_en) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        idx = rd_ptr_q + PtrW'(i);
        if (valid_q[idx] &&
            addr_q[idx][ADDR_WIDTH-1:OffW] == bus.lookup_addr[ADDR_WIDTH-1:OffW]) begin
          hit   = 1'b1;
          fdata = data_q[idx];
        end
      end
    end
  end

  assign bus.fwd_hit    = hit;
  assign bus.fwd_data   = fdata;
  assign unused_lookup_lo = ^bus.lookup_addr[OffW-1:0];
`else
  logic unused_fwd;

  assign bus.fwd_hit  = 1'b0;
  assign bus.fwd_data = '0;
  assign unused_fwd   = ^{valid_q, bus.lookup_en, bus.lookup_addr};
`endif
endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer: vector table for fill/drain plus hand sequences.
module tb_write_buffer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned LW    = 128;
`ifdef WRITE_BUFFER_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  write_buffer_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

  write_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          en;
    logic [AW-1:0] addr;
    logic          ack;
    logic          exp_full;
    logic          exp_empty;
    logic          exp_ovf;
    logic          exp_req;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t vecs [15];

  function automatic logic [LW-1:0] mkdata(input logic [AW-1:0] a);
    return {4{a}};
  endfunction

  task automatic check(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.write_buffer_en      = 1'b0;
    bus.addr_to_write_buffer = '0;
    bus.data_to_write_buffer = '0;
    bus.mem_wr_ack           = 1'b0;
    bus.lookup_en            = 1'b0;
    bus.lookup_addr          = '0;
  endtask

  // Called 1 time unit after an edge, so the pulse never straddles one.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic push_one(input logic [AW-1:0] a, input logic [LW-1:0] d);
    bus.write_buffer_en      = 1'b1;
    bus.addr_to_write_buffer = a;
    bus.data_to_write_buffer = d;
    step();
    bus.write_buffer_en      = 1'b0;
  endtask

  initial begin
    logic [LW-1:0] da, db;
    da = {32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003, 32'hAAAA_0004};
    db = {32'hBBBB_0001, 32'hBBBB_0002, 32'hBBBB_0003, 32'hBBBB_0004};

    //            en    addr        ack   full  empty ovf   req   exp_addr
    vecs[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100};
    vecs[2]  = '{1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100};
    vecs[3]  = '{1'b1, 32'h400, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100};
    vecs[4]  = '{1'b1, 32'h500, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100};
    vecs[5]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100};
    vecs[6]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200};
    vecs[7]  = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h200};
    vecs[8]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h300};
    vecs[9]  = '{1'b1, 32'h600, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h300};
    vecs[10] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h400};
    vecs[11] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h400};
    vecs[12] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h600};
    vecs[13] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h600};
    vecs[14] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h600};

    idle_inputs();
    rst_n = 1'b0;
    #12;
    check("rst empty", bus.wb_empty, 1);
    check("rst full", bus.wb_full, 0);
    check("rst ovf", bus.wb_overflow, 0);
    check("rst req", bus.mem_wr_req, 0);
    check("rst addr", bus.mem_wr_addr, 0);
    check("rst data", bus.mem_wr_data, 0);
    check("rst hit", bus.fwd_hit, 0);
    check("rst fdata", bus.fwd_data, 0);
    rst_n = 1'b1;
    step();

    // Fill, overflow, in-order drain, simultaneous push+ack at count 2.
    for (int i = 0; i < 15; i++) begin
      bus.write_buffer_en      = vecs[i].en;
      bus.addr_to_write_buffer = vecs[i].addr;
      bus.data_to_write_buffer = mkdata(vecs[i].addr);
      bus.mem_wr_ack           = vecs[i].ack;
      step();
      check($sformatf("v%0d full", i), bus.wb_full, vecs[i].exp_full);
      check($sformatf("v%0d empty", i), bus.wb_empty, vecs[i].exp_empty);
      check($sformatf("v%0d ovf", i), bus.wb_overflow, vecs[i].exp_ovf);
      check($sformatf("v%0d req", i), bus.mem_wr_req, vecs[i].exp_req);
      check($sformatf("v%0d addr", i), bus.mem_wr_addr, vecs[i].exp_addr);
      check($sformatf("v%0d data", i), bus.mem_wr_data, mkdata(vecs[i].exp_addr));
    end
    do_reset();
    check("ovf cleared by reset", bus.wb_overflow, 0);
    step();

    // Single push with ack held high: request two edges after the push.
    bus.mem_wr_ack = 1'b1;
    push_one(32'h0000_1040, {4{32'h1111_1111}});
    check("single req lat1", bus.mem_wr_req, 0);
    check("single not empty", bus.wb_empty, 0);
    step();
    check("single req", bus.mem_wr_req, 1);
    check("single addr", bus.mem_wr_addr, 32'h1040);
    check("single data", bus.mem_wr_data, {4{32'h1111_1111}});
    step();
    check("single popped req", bus.mem_wr_req, 0);
    check("single empty", bus.wb_empty, 1);
    step();
    check("single no 2nd req", bus.mem_wr_req, 0);
    bus.mem_wr_ack = 1'b0;

    // Backpressure: 10 cycles of no ack in REQ; push 0x600 in the window.
    push_one(32'hA00, mkdata(32'hA00));
    step();
    for (int k = 0; k < 10; k++) begin
      bus.write_buffer_en      = (k == 3);
      bus.addr_to_write_buffer = 32'h600;
      bus.data_to_write_buffer = mkdata(32'h600);
      check($sformatf("bp%0d req", k), bus.mem_wr_req, 1);
      check($sformatf("bp%0d addr", k), bus.mem_wr_addr, 32'hA00);
      check($sformatf("bp%0d data", k), bus.mem_wr_data, mkdata(32'hA00));
      step();
    end
    bus.write_buffer_en = 1'b0;
    bus.mem_wr_ack      = 1'b1;
    step();
    check("bp pop req", bus.mem_wr_req, 0);
    check("bp queued", bus.wb_empty, 0);
    bus.mem_wr_ack = 1'b0;
    step();
    check("bp 2nd req", bus.mem_wr_req, 1);
    check("bp 2nd addr", bus.mem_wr_addr, 32'h600);
    bus.mem_wr_ack = 1'b1;
    step();
    check("bp drained", bus.wb_empty, 1);
    bus.mem_wr_ack = 1'b0;

    // Forwarding: two entries on the same line, youngest wins.
    do_reset();
    step();
    push_one(32'h1040, da);
    push_one(32'h1048, db);
    check("fwd head in req", bus.mem_wr_req, 1);
    bus.lookup_en   = 1'b1;
    bus.lookup_addr = 32'h104C;
    #1;
    check("fwd hit", bus.fwd_hit, FWD);
    check("fwd data", bus.fwd_data, FWD ? db : '0);
    bus.lookup_addr = 32'h2000;
    #1;
    check("fwd miss hit", bus.fwd_hit, 0);
    check("fwd miss data", bus.fwd_data, 0);
    bus.lookup_en   = 1'b0;
    bus.lookup_addr = 32'h1040;
    #1;
    check("fwd disabled hit", bus.fwd_hit, 0);
    bus.lookup_en = 1'b0;

    // Async reset while in REQ with three entries queued.
    do_reset();
    step();
    push_one(32'h10, mkdata(32'h10));
    push_one(32'h20, mkdata(32'h20));
    push_one(32'h30, mkdata(32'h30));
    check("ar req before", bus.mem_wr_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar req dropped", bus.mem_wr_req, 0);
    check("ar empty", bus.wb_empty, 1);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("ar%0d req", k), bus.mem_wr_req, 0);
      check($sformatf("ar%0d empty", k), bus.wb_empty, 1);
      check($sformatf("ar%0d ovf", k), bus.wb_overflow, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/write_buffer.md
Name: write_buffer

Overview:
- Sits directly downstream of the cache top. Captures dirty cachelines the data RAM evicts (write_buffer_en / addr_to_write_buffer / data_to_write_buffer).
- Queues them in a small FIFO and drains them one at a time to main memory over a req/ack handshake.
- Exposes full/empty status so the cache pipeline can stall.
- Provides a line-address lookup port so a refill read never fetches stale data from memory.

Parameters:
- DEPTH, 4, number of line entries; power of two, min 2.
- ADDR_WIDTH, 32, byte address width; matches `ADDR_WIDTH.
- LINE_WIDTH, 128, cacheline width in bits; matches `CACHELINE_WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- write_buffer_en  in  1  push request from cache.
- addr_to_write_buffer  in  ADDR_WIDTH  evicted line address.
- data_to_write_buffer  in  LINE_WIDTH  evicted line data.
- wb_full  out  1  count == DEPTH.
- wb_empty  out  1  count == 0.
- wb_overflow  out  1  sticky: push attempted while full.
- mem_wr_req  out  1  write request to main memory.
- mem_wr_addr  out  ADDR_WIDTH  address of head entry.
- mem_wr_data  out  LINE_WIDTH  data of head entry.
- mem_wr_ack  in  1  memory accepted current write.
- lookup_en  in  1  cache is issuing a refill read.
- lookup_addr  in  ADDR_WIDTH  refill read address.
- fwd_hit  out  1  lookup matches a valid entry.
- fwd_data  out  LINE_WIDTH  matching line data.

Behaviour:
- Reset (async, rst_n=0): count=0, wr_ptr=rd_ptr=0, all valid bits cleared, state=IDLE.
  - Outputs: wb_empty=1, wb_full=0, wb_overflow=0, mem_wr_req=0, mem_wr_addr=0, mem_wr_data=0, fwd_hit=0, fwd_data=0.
  - Reset mid-drain drops mem_wr_req immediately and discards all entries.
- wb_full and wb_empty are decoded from the registered count.
- Push: write_buffer_en && !wb_full at edge N.
  - Entry written at wr_ptr; wr_ptr increments mod DEPTH; count increments.
  - wb_empty falls after edge N.
- Push while wb_full: rejected even if a pop occurs in the same cycle. Contents unchanged; wb_overflow set and held until reset.
- Drain FSM, 2 states:
  - IDLE: if count>0, go to REQ at the next edge, latching head addr/data into the mem_wr_* registers. mem_wr_req=0 in IDLE.
  - REQ: mem_wr_req=1. mem_wr_addr/mem_wr_data stay stable until ack.
  - On mem_wr_ack in REQ: pop the head (rd_ptr++, count--, valid cleared) and return to IDLE.
  - Consequence: a minimum of 2 cycles per entry, and mem_wr_req is low for at least one cycle between entries.
  - mem_wr_ack outside REQ is ignored.
- First request timing: push at edge N gives mem_wr_req=1 during the cycle after edge N+1, i.e. 2-cycle push-to-request latency from an empty buffer.
- Simultaneous push and pop (not full): both pointers advance and count is unchanged.
- Ordering: strict FIFO; memory sees writes in push order.
- Address match:
  - Line-aligned comparison; the low log2(LINE_WIDTH/8) address bits are ignored.
  - The entry currently in REQ stays valid and matchable until its ack edge.
  - Duplicate addresses are allowed as separate entries.

Optional Feature:
- Macro: WRITE_BUFFER_FORWARD_EN.
- Defined:
  - fwd_hit and fwd_data are combinational in the same cycle as lookup_en.
  - Compares lookup_addr against all valid entries; on multiple matches, the youngest entry wins.
  - A same-cycle push is not visible to the lookup until the next cycle.
  - fwd_data=0 when fwd_hit=0.
- Undefined:
  - No comparators are built; fwd_hit=0 and fwd_data=0 at all times.
  - The cache must hold read_main_memory_en until wb_empty=1.

Test Plan:
- Single push: addr 0x0000_1040, data 0x1111…; mem_wr_ack held 1 -> mem_wr_req high 2 cycles after push with addr 0x1040. Pops at first ack edge; wb_empty=1 one cycle later.
- Fill: 4 pushes 0x100/0x200/0x300/0x400 with ack=0 -> wb_full=1 after 4th edge. 5th push 0x500 sets wb_overflow=1 and is dropped. Acks then drain exactly 0x100, 0x200, 0x300, 0x400 in order.
- Backpressure: ack held 0 for 10 cycles in REQ -> mem_wr_req, addr and data stable all 10 cycles. A push of 0x600 in that window is queued behind the head.
- Simultaneous push + ack at count=2 -> count stays 2, FIFO order preserved.
- Forwarding (WRITE_BUFFER_FORWARD_EN): entries 0x1040 (data A) then 0x1048 (data B, same line) -> lookup 0x104C gives fwd_hit=1, fwd_data=B. Lookup 0x2000 gives fwd_hit=0. Without the macro, fwd_hit is always 0.
- Async reset asserted mid-REQ with 3 entries -> mem_wr_req drops without waiting for an edge; after release wb_empty=1, wb_overflow=0, and no further requests.
